parking_lot_sensor_gen: RTL and testbench

//  Drives the two parking-gate photo-sensor lines (A outer, B inner) with legal car-enter or car-exit waveforms.

---
 rtl/parking_lot_sensor_gen_pkg.sv | 15 +
 rtl/parking_lot_sensor_gen_dwell_timer.sv | 18 +
 rtl/parking_lot_sensor_gen.sv | 80 ++++++++
 tb/tb_parking_lot_sensor_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/parking_lot_sensor_gen_pkg.sv
// parking_lot_sensor_gen_pkg: shared state encodings, direction values and {A,B} phase codes for the gate sensor protocol.
package parking_lot_sensor_gen_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, PH0 = 3'd1, PH1 = 3'd2, PH2 = 3'd3, PH3 = 3'd4, DONE = 3'd5} state_t;
  localparam logic DIR_ENTER = 1'b0;
  localparam logic DIR_EXIT = 1'b1;
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_OUTER = 2'b10;
  localparam logic [1:0] AB_INNER = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;
  function automatic logic [1:0] phaseCode(input state_t s, input logic dir);
    return s == PH0 ? (dir == DIR_EXIT ? AB_INNER : AB_OUTER) :
           s == PH1 ? AB_BOTH :
           s == PH2 ? (dir == DIR_EXIT ? AB_OUTER : AB_INNER) : AB_NONE;
  endfunction
endpackage

// File: rtl/parking_lot_sensor_gen_dwell_timer.sv
// parking_dwell_timer: loadable down-counter that holds at zero and flags it.
module parking_dwell_timer #(
  parameter int DW = 8
) (
  input  logic          iCLK,
  input  logic          iRESET_N,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] loadVal,
  output logic          zero
);
  logic [DW-1:0] cnt;
  always_ff @(posedge iCLK or negedge iRESET_N)
    if (!iRESET_N) cnt <= '0;
    else if (load) cnt <= loadVal;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/parking_lot_sensor_gen.sv
// parking_lot_sensor_gen: drives A/B gate sensor lines with 4-phase enter/exit waveforms.
// Build option PARKING_GEN_ERR_INJECT_EN adds iINJ_ERR to skip the 11 phase (illegal sequence).
module parking_lot_sensor_gen
  import parking_lot_sensor_gen_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          iCLK,
  input  logic          iRESET_N,
  input  logic          iSTART,
  input  logic          iDIR,
  input  logic [DW-1:0] iDWELL,
  input  logic          iABORT,
`ifdef PARKING_GEN_ERR_INJECT_EN
  input  logic          iINJ_ERR,
`endif
  output logic          oA,
  output logic          oB,
  output logic          oREADY,
  output logic          oBUSY,
  output logic          oDONE
);
  state_t state, nextState, succState;
  logic dirReg, skipOne, accept, timerLoad, timerEn, timerZero;
  logic [DW-1:0] reloadReg, startReload, loadVal;
  assign accept = state == IDLE && iSTART && !iABORT;
  assign startReload = iDWELL == '0 ? '0 : iDWELL - 1'b1;
  assign loadVal = state == IDLE ? startReload : reloadReg;
  always_ff @(posedge iCLK or negedge iRESET_N)
    if (!iRESET_N) begin
      state <= IDLE;
      dirReg <= DIR_ENTER;
      reloadReg <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        dirReg <= iDIR;
        reloadReg <= startReload;
      end
    end
`ifdef PARKING_GEN_ERR_INJECT_EN
  always_ff @(posedge iCLK or negedge iRESET_N)
    if (!iRESET_N) skipOne <= 1'b0;
    else if (accept) skipOne <= iINJ_ERR;
`else
  assign skipOne = 1'b0;
`endif
  assign succState = state == PH0 ? (skipOne ? PH2 : PH1) :
                     state == PH1 ? PH2 :
                     state == PH2 ? PH3 : DONE;
  always_comb begin
    nextState = state;
    timerLoad = 1'b0;
    timerEn = 1'b0;
    case (state)
      IDLE: if (accept) begin
        nextState = PH0;
        timerLoad = 1'b1;
      end
      PH0, PH1, PH2, PH3: if (iABORT) nextState = IDLE;
        else if (timerZero) begin
          nextState = succState;
          timerLoad = 1'b1;
        end else timerEn = 1'b1;
      default: nextState = IDLE;
    endcase
  end
  parking_dwell_timer #(.DW(DW)) uTimer (
    .iCLK(iCLK),
    .iRESET_N(iRESET_N),
    .load(timerLoad),
    .en(timerEn),
    .loadVal(loadVal),
    .zero(timerZero)
  );
  assign {oA, oB} = phaseCode(state, dirReg);
  assign oBUSY = state == PH0 || state == PH1 || state == PH2 || state == PH3;
  assign oDONE = state == DONE;
  assign oREADY = state == IDLE;
endmodule

// File: tb/tb_parking_lot_sensor_gen.sv
// tb_parking_lot_sensor_gen: directed scenario checks of the gate sensor waveform generator.
module tb_parking_lot_sensor_gen;
  logic iCLK = 1'b0, iRESET_N = 1'b0, iSTART = 1'b0, iDIR = 1'b0, iABORT = 1'b0;
  logic [7:0] iDWELL = '0;
  logic oA, oB, oREADY, oBUSY, oDONE;
  int passCnt = 0, totalCnt = 0;
`ifdef PARKING_GEN_ERR_INJECT_EN
  logic iINJ_ERR = 1'b0;
`endif
  parking_lot_sensor_gen #(.DW(8)) dut (
    .iCLK(iCLK),
    .iRESET_N(iRESET_N),
    .iSTART(iSTART),
    .iDIR(iDIR),
    .iDWELL(iDWELL),
    .iABORT(iABORT),
`ifdef PARKING_GEN_ERR_INJECT_EN
    .iINJ_ERR(iINJ_ERR),
`endif
    .oA(oA),
    .oB(oB),
    .oREADY(oREADY),
    .oBUSY(oBUSY),
    .oDONE(oDONE)
  );
  always #5 iCLK = ~iCLK;
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask
  task automatic startCmd(input logic dir, input logic [7:0] dwell, input logic inj);
    iSTART = 1'b1;
    iDIR = dir;
    iDWELL = dwell;
`ifdef PARKING_GEN_ERR_INJECT_EN
    iINJ_ERR = inj;
`endif
    step();
    iSTART = 1'b0;
    iDIR = ~dir;
    iDWELL = 8'd7;
`ifdef PARKING_GEN_ERR_INJECT_EN
    iINJ_ERR = 1'b0;
`endif
  endtask
  task automatic test_reset();
    #1;
    totalCnt++;
    if ({oA, oB, oBUSY, oDONE, oREADY} !== 5'b00001) $display("FAIL reset_state got %b want 00001", {oA, oB, oBUSY, oDONE, oREADY});
    else passCnt++;
    iRESET_N = 1'b1;
    step();
    startCmd(1'b0, 8'd3, 1'b0);
    repeat (3) step();
    totalCnt++;
    if ({oA, oB, oBUSY} !== 3'b111) $display("FAIL reset_pre_ph1 got %b want 111", {oA, oB, oBUSY});
    else passCnt++;
    #2 iRESET_N = 1'b0;
    #1;
    totalCnt++;
    if ({oA, oB, oBUSY, oDONE, oREADY} !== 5'b00001) $display("FAIL reset_async got %b want 00001", {oA, oB, oBUSY, oDONE, oREADY});
    else passCnt++;
    step();
    iRESET_N = 1'b1;
    step();
  endtask
  task automatic test_sequence(input string name, input logic dir, input logic [7:0] dwell, input logic inj);
    logic [1:0] ph[4];
    logic [1:0] seq[4];
    logic [1:0] expAb;
    int d, n, k;
    ph = dir ? '{2'b01, 2'b11, 2'b10, 2'b00} : '{2'b10, 2'b11, 2'b01, 2'b00};
    n = 0;
    for (int i = 0; i < 4; i++) if (!(inj && i == 1)) begin
      seq[n] = ph[i];
      n++;
    end
    d = dwell == 0 ? 1 : int'(dwell);
    startCmd(dir, dwell, inj);
    for (int c = 1; c <= n * d + 1; c++) begin
      k = (c - 1) / d;
      expAb = c <= n * d ? seq[k] : 2'b00;
      totalCnt++;
      if ({oA, oB, oBUSY, oDONE, oREADY} !== {expAb, c <= n * d, c == n * d + 1, 1'b0})
        $display("FAIL %s cycle %0d got %b want %b", name, c, {oA, oB, oBUSY, oDONE, oREADY}, {expAb, c <= n * d, c == n * d + 1, 1'b0});
      else passCnt++;
      step();
    end
    totalCnt++;
    if ({oA, oB, oBUSY, oDONE, oREADY} !== 5'b00001) $display("FAIL %s_idle got %b want 00001", name, {oA, oB, oBUSY, oDONE, oREADY});
    else passCnt++;
  endtask
  task automatic test_ignored_start();
    int dones = 0;
    startCmd(1'b0, 8'd2, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (oDONE) dones++;
      iSTART = c == 5 || c == 9;
      iDIR = 1'b1;
      iDWELL = 8'd5;
      if (c == 7) begin
        totalCnt++;
        if ({oA, oB, oBUSY} !== 3'b001) $display("FAIL ign_ph3 got %b want 001", {oA, oB, oBUSY});
        else passCnt++;
      end
      if (c == 10) begin
        totalCnt++;
        if ({oBUSY, oREADY} !== 2'b01) $display("FAIL ign_after_done got %b want 01", {oBUSY, oREADY});
        else passCnt++;
      end
      step();
    end
    iSTART = 1'b0;
    totalCnt++;
    if (dones !== 1) $display("FAIL ign_done_count got %0d want 1", dones);
    else passCnt++;
  endtask
  task automatic test_abort();
    int dones = 0;
    startCmd(1'b0, 8'd4, 1'b0);
    repeat (5) step();
    totalCnt++;
    if ({oA, oB, oBUSY} !== 3'b111) $display("FAIL abort_pre got %b want 111", {oA, oB, oBUSY});
    else passCnt++;
    iABORT = 1'b1;
    step();
    iABORT = 1'b0;
    totalCnt++;
    if ({oA, oB, oBUSY, oREADY} !== 4'b0001) $display("FAIL abort_next got %b want 0001", {oA, oB, oBUSY, oREADY});
    else passCnt++;
    repeat (20) begin
      if (oDONE) dones++;
      step();
    end
    totalCnt++;
    if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones);
    else passCnt++;
    iABORT = 1'b1;
    iSTART = 1'b1;
    step();
    iABORT = 1'b0;
    iSTART = 1'b0;
    totalCnt++;
    if ({oBUSY, oREADY} !== 2'b01) $display("FAIL abort_wins_start got %b want 01", {oBUSY, oREADY});
    else passCnt++;
  endtask
  initial begin
    test_reset();
    test_sequence("enter_d3", 1'b0, 8'd3, 1'b0);
    test_sequence("exit_d0", 1'b1, 8'd0, 1'b0);
    test_ignored_start();
    test_sequence("exit_d2", 1'b1, 8'd2, 1'b0);
    test_abort();
    test_sequence("enter_d1", 1'b0, 8'd1, 1'b0);
`ifdef PARKING_GEN_ERR_INJECT_EN
    test_sequence("inject_d2", 1'b0, 8'd2, 1'b1);
`endif
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
